ddc_accumulator: RTL

Boxcar integrate-and-dump decimator sitting directly downstream of the DDC core. It consumes the DDC's 64-bit I/Q stream (29-bit signed I in [28:0], 29-bit signed Q in [60:32]) and sums 2^len consecutive samples per channel. It emits the arithmetic-shifted average on an AXI4-Stream master through a 2-entry output FIFO, and flags any results dropped to backpressure.

---
 rtl/ddc_accumulator.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ddc_accumulator.sv
// ddc_accumulator
//   Boxcar integrate-and-dump decimator for the DDC I/Q stream. Sums 2^len
//   consecutive samples per channel, divides by arithmetic shift and hands
//   the averages to an AXI4-Stream master through a 2-entry FIFO. Results
//   that arrive while the FIFO is full and not popping are dropped and
//   counted.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   ddc_in[63:0]   I = [28:0], Q = [60:32], both signed; other bits ignored
//   valid_in       ddc_in valid this cycle (no backpressure upstream)
//   len_in[3:0]    decimation exponent, clamped to MAX_LOG2
//   len_valid      load len_in and restart the frame
//   m_axis_tdata   {Q avg sext 32, I avg sext 32}, always the FIFO head
//   m_axis_tvalid  FIFO non-empty
//   m_axis_tready  downstream accept
//   overflow       sticky, at least one result dropped since rst
//   drop_count     saturating count of dropped results
module ddc_accumulator #(
  parameter int MAX_LOG2   = 12,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           ddc_in,
  input  logic                  valid_in,
  input  logic [3:0]            len_in,
  input  logic                  len_valid,
  output logic [63:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int         ACC_W   = 29 + MAX_LOG2;
  localparam int         CNT_W   = MAX_LOG2;
  localparam logic [3:0] MAX_LEN = 4'(MAX_LOG2);

  // Front end: frame length, sample counter and accumulators
  logic [3:0]              len_r;
  logic [CNT_W-1:0]        cnt_r;
  logic signed [ACC_W-1:0] acc_i_r;
  logic signed [ACC_W-1:0] acc_q_r;

  logic [3:0]              len_clamp_s;
  logic [CNT_W-1:0]        last_cnt_s;
  logic signed [ACC_W-1:0] sample_i_s;
  logic signed [ACC_W-1:0] sample_q_s;
  logic signed [ACC_W-1:0] sum_i_s;
  logic signed [ACC_W-1:0] sum_q_s;
  logic                    take_s;
  logic                    last_s;

  // Dump stage 1: final sum plus the shift that belongs to it
  logic                    res_pend_r;
  logic signed [ACC_W-1:0] res_i_r;
  logic signed [ACC_W-1:0] res_q_r;
  logic [3:0]              res_len_r;

  // Dump stage 2: formatted average waiting to be pushed
  logic                    avg_pend_r;
  logic [63:0]             avg_data_r;
  logic signed [ACC_W-1:0] shift_i_s;
  logic signed [ACC_W-1:0] shift_q_s;
  logic [28:0]             avg_i_s;
  logic [28:0]             avg_q_s;

  // Output FIFO: head_r is always the word on the bus, tail_r the second
  logic [63:0]             head_r;
  logic [63:0]             tail_r;
  logic [1:0]              count_r;
  logic                    tvalid_r;
  logic                    overflow_r;
  logic [DROP_CNT_W-1:0]   drop_cnt_r;

  logic [63:0]             head_n_s;
  logic [63:0]             tail_n_s;
  logic [1:0]              count_n_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    drop_s;

  logic                    unused_s;

  // Front-end combinational decode: clamp, frame end, running sum
  always_comb begin
    len_clamp_s = len_in;
    if (len_in > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = len_in;
    end

    // N-1 as a mask: shifting past the counter width leaves all ones
    last_cnt_s = ~({CNT_W{1'b1}} << len_r);

    sample_i_s = {{MAX_LOG2{ddc_in[28]}}, ddc_in[28:0]};
    sample_q_s = {{MAX_LOG2{ddc_in[60]}}, ddc_in[60:32]};

    // First sample of a frame loads instead of adding, so frames abut
    if (cnt_r == {CNT_W{1'b0}}) begin
      sum_i_s = sample_i_s;
      sum_q_s = sample_q_s;
    end else begin
      sum_i_s = acc_i_r + sample_i_s;
      sum_q_s = acc_q_r + sample_q_s;
    end

    take_s = valid_in && !len_valid;
    last_s = take_s && (cnt_r == last_cnt_s);
  end

  // Front-end state: reconfiguration wins over a coincident sample
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r   <= 4'd0;
      cnt_r   <= {CNT_W{1'b0}};
      acc_i_r <= {ACC_W{1'b0}};
      acc_q_r <= {ACC_W{1'b0}};
    end else if (len_valid) begin
      len_r <= len_clamp_s;
      cnt_r <= {CNT_W{1'b0}};
    end else if (valid_in) begin
      acc_i_r <= sum_i_s;
      acc_q_r <= sum_q_s;
      if (last_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Dump stage 1: latch the completed frame sum with its own shift amount
  always_ff @(posedge clk) begin
    if (rst) begin
      res_pend_r <= 1'b0;
      res_i_r    <= {ACC_W{1'b0}};
      res_q_r    <= {ACC_W{1'b0}};
      res_len_r  <= 4'd0;
    end else begin
      res_pend_r <= last_s;
      if (last_s) begin
        res_i_r   <= sum_i_s;
        res_q_r   <= sum_q_s;
        res_len_r <= len_r;
      end
    end
  end

  // Average: arithmetic shift floors toward -inf; the result always fits 29 bits
  always_comb begin
    shift_i_s = res_i_r >>> res_len_r;
    shift_q_s = res_q_r >>> res_len_r;
    avg_i_s   = shift_i_s[28:0];
    avg_q_s   = shift_q_s[28:0];
  end

  // Dump stage 2: register the sign-extended output word
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_pend_r <= 1'b0;
      avg_data_r <= 64'd0;
    end else begin
      avg_pend_r <= res_pend_r;
      if (res_pend_r) begin
        avg_data_r <= {{3{avg_q_s[28]}}, avg_q_s, {3{avg_i_s[28]}}, avg_i_s};
      end
    end
  end

  // FIFO next-state: shift-register style so the head stays in a register
  always_comb begin
    push_s    = avg_pend_r;
    pop_s     = (count_r != 2'd0) && m_axis_tready;
    head_n_s  = head_r;
    tail_n_s  = tail_r;
    count_n_s = count_r;
    drop_s    = 1'b0;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          head_n_s  = avg_data_r;
          count_n_s = 2'd1;
        end else begin
          count_n_s = 2'd0;
        end
      end
      2'd1: begin
        if (pop_s && push_s) begin
          head_n_s = avg_data_r;
        end else if (pop_s) begin
          count_n_s = 2'd0;
        end else if (push_s) begin
          tail_n_s  = avg_data_r;
          count_n_s = 2'd2;
        end else begin
          count_n_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s && push_s) begin
          head_n_s = tail_r;
          tail_n_s = avg_data_r;
        end else if (pop_s) begin
          head_n_s  = tail_r;
          count_n_s = 2'd1;
        end else if (push_s) begin
          drop_s = 1'b1;
        end else begin
          count_n_s = 2'd2;
        end
      end
      default: begin
        count_n_s = 2'd0;
      end
    endcase
  end

  // FIFO storage, valid flag and drop bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= 64'd0;
      tail_r     <= 64'd0;
      count_r    <= 2'd0;
      tvalid_r   <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else begin
      head_r   <= head_n_s;
      tail_r   <= tail_n_s;
      count_r  <= count_n_s;
      tvalid_r <= (count_n_s != 2'd0);
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {DROP_CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign m_axis_tdata  = head_r;
  assign m_axis_tvalid = tvalid_r;
  assign overflow      = overflow_r;
  assign drop_count    = drop_cnt_r;

  assign unused_s = ^{ddc_in[63:61], ddc_in[31:29],
                      shift_i_s[ACC_W-1:29], shift_q_s[ACC_W-1:29]};

endmodule
